// File: rtl/pong_pkg.sv
// Shared encodings and helpers for the Pong datapath.
`default_nettype none

package pong_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SERVE  = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  localparam logic [1:0] LEVEL_MAX = 2'd3;
  localparam int         DIV_W     = 3;

  // Low bits of div_cnt that must all be set for a strobe: (1 << (3-level)) - 1.
  function automatic logic [DIV_W-1:0] level_mask(input logic [1:0] lvl);
    logic [DIV_W-1:0] m;
    m = '0;
    case (lvl)
      2'd0:    m = 3'b111;
      2'd1:    m = 3'b011;
      2'd2:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// Free-running prescaler; base_tick marks the last count of each 2^PRE_W window.
`default_nettype none

module tick_prescaler #(
  parameter int PRE_W = 18
) (
  input  logic clk,
  input  logic clr_n,
  output logic base_tick
);

  logic [PRE_W-1:0] pre_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign base_tick = &pre_cnt;

endmodule

`default_nettype wire

// File: rtl/move_tick_ctrl.sv
// Ball-motion scheduler: serve/play/pause FSM producing rate-scaled move_stb enables.
`default_nettype none

module move_tick_ctrl
  import pong_pkg::*;
#(
  parameter int PRE_W          = 18,
  parameter int SERVE_TICKS    = 128,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       serve,
  input  logic       hit,
  input  logic       miss,
  input  logic       pause,
  output logic       move_stb,
  output logic [1:0] level,
  output logic [1:0] state,
  output logic       playing
);

  localparam logic [7:0] SRV_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [3:0] HIT_LAST = 4'(HITS_PER_LEVEL - 1);

  logic             base_tick;
  logic [7:0]       srv_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       hit_cnt;
  logic [DIV_W-1:0] mask;

  tick_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .clr_n    (clr_n),
    .base_tick(base_tick)
  );

  assign mask    = level_mask(level);
  assign playing = (state == ST_PLAY);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      srv_cnt  <= '0;
      div_cnt  <= '0;
      hit_cnt  <= '0;
      level    <= '0;
      move_stb <= 1'b0;
    end else begin
      move_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (serve) begin
            state   <= ST_SERVE;
            srv_cnt <= '0;
          end
        end

        ST_SERVE: begin
          if (base_tick && !pause) begin
            if (srv_cnt == SRV_LAST) begin
              state   <= ST_PLAY;
              div_cnt <= '0;
            end else begin
              srv_cnt <= srv_cnt + 8'd1;
            end
          end
        end

        ST_PLAY: begin
          // A tick in the same cycle as pause rising still advances the divider.
          if (base_tick) begin
            div_cnt <= div_cnt + 1'b1;
            if ((div_cnt & mask) == mask) begin
              move_stb <= 1'b1;
            end
          end
          if (miss) begin
            state   <= ST_IDLE;
            level   <= '0;
            hit_cnt <= '0;
          end else begin
            if (pause) begin
              state <= ST_PAUSED;
            end
            if (hit) begin
              if (hit_cnt == HIT_LAST) begin
                hit_cnt <= '0;
                if (level != LEVEL_MAX) begin
                  level <= level + 2'd1;
                end
              end else begin
                hit_cnt <= hit_cnt + 4'd1;
              end
            end
          end
        end

        ST_PAUSED: begin
          if (miss) begin
            state   <= ST_IDLE;
            level   <= '0;
            hit_cnt <= '0;
          end else if (!pause) begin
            state <= ST_PLAY;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_move_tick_ctrl.sv
// Scoreboard bench for move_tick_ctrl with PRE_W=4, SERVE_TICKS=2, HITS_PER_LEVEL=2.
`default_nettype none

module tb_move_tick_ctrl;

  logic       clk;
  logic       clr_n;
  logic       serve;
  logic       hit;
  logic       miss;
  logic       pause;
  logic       move_stb;
  logic [1:0] level;
  logic [1:0] state;
  logic       playing;

  int total;
  int bad;
  int cyc;
  int exp_q[$];

  move_tick_ctrl #(
    .PRE_W         (4),
    .SERVE_TICKS   (2),
    .HITS_PER_LEVEL(2)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .serve   (serve),
    .hit     (hit),
    .miss    (miss),
    .pause   (pause),
    .move_stb(move_stb),
    .level   (level),
    .state   (state),
    .playing (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the number of rising edges since clr_n was released, i.e. pre_cnt's count.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: every strobe seen must match the next expected strobe cycle.
  always @(negedge clk) begin
    if (clr_n && move_stb) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL move_stb_unexpected: strobe at cyc=%0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc != e) begin
          bad = bad + 1;
          $display("FAIL move_stb_time: strobe at cyc=%0d, expected cyc=%0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the falling edge where cyc == k; inputs set here are sampled at edge k+1.
  task automatic go(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != k && guard < 3000);
    if (cyc != k) begin
      bad = bad + 1;
      total = total + 1;
      $display("FAIL timeout: waiting for cyc=%0d, at cyc=%0d", k, cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_n = 1'b0;
    serve = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_level", level, 0);
    chk("reset_playing", playing, 0);
    chk("reset_stb", move_stb, 0);
    clr_n = 1'b1;

    go(200);
    chk("idle_state", state, 0);
    chk("idle_level", level, 0);

    // Serve at 208; play from 240; level-0 strobes every 8 ticks (128 clocks).
    // Pause spans ticks 512..592 so the third strobe slips to 720.
    exp_q.push_back(368);
    exp_q.push_back(496);
    exp_q.push_back(720);
    go(207); serve = 1'b1;
    go(208); serve = 1'b0;
    chk("serve_state", state, 1);
    go(239);
    chk("serve_hold", state, 1);
    go(240);
    chk("play_state", state, 2);
    chk("play_playing", playing, 1);

    go(499); pause = 1'b1;
    go(550);
    chk("paused_state", state, 3);
    chk("paused_playing", playing, 0);
    go(599); pause = 1'b0;
    go(600);
    chk("resume_state", state, 2);

    // Two hits -> level 1, 64-clock spacing.
    exp_q.push_back(784);
    exp_q.push_back(848);
    go(729); hit = 1'b1;
    go(730); hit = 1'b0;
    chk("one_hit_level", level, 0);
    go(731); hit = 1'b1;
    go(732); hit = 1'b0;
    chk("level1", level, 1);

    // Six more hits -> level 3 saturated, strobe every tick.
    exp_q.push_back(864);
    exp_q.push_back(880);
    exp_q.push_back(896);
    exp_q.push_back(912);
    for (int i = 0; i < 6; i++) begin
      go(851 + 2 * i); hit = 1'b1;
      go(852 + 2 * i); hit = 1'b0;
      if (i == 1) chk("level2", level, 2);
    end
    go(870);
    chk("level_sat", level, 3);

    go(919); hit = 1'b1; miss = 1'b1;
    go(920); hit = 1'b0; miss = 1'b0;
    chk("miss_l3_state", state, 0);
    chk("miss_l3_level", level, 0);
    chk("miss_l3_playing", playing, 0);

    // Re-serve, climb to level 2 (mask 1): strobes on odd div_cnt.
    exp_q.push_back(992);
    exp_q.push_back(1024);
    go(929); serve = 1'b1;
    go(930); serve = 1'b0;
    go(960);
    chk("replay_state", state, 2);
    go(961); hit = 1'b1;
    go(962); hit = 1'b0;
    go(964);
    chk("hitcnt_cleared", level, 0);
    for (int i = 0; i < 3; i++) begin
      go(965 + 2 * i); hit = 1'b1;
      go(966 + 2 * i); hit = 1'b0;
    end
    go(972);
    chk("relevel2", level, 2);
    go(999); hit = 1'b1;
    go(1000); hit = 1'b0;
    go(1002);
    chk("half_group_level", level, 2);

    // Hit that would complete a group collides with miss: miss must win.
    go(1029); hit = 1'b1; miss = 1'b1;
    go(1030); hit = 1'b0; miss = 1'b0;
    chk("hitmiss_state", state, 0);
    chk("hitmiss_level", level, 0);

    // Clear during SERVE, then full serve delay again.
    go(1039); serve = 1'b1;
    go(1040); serve = 1'b0;
    chk("serve2_state", state, 1);
    go(1050);
    #2 clr_n = 1'b0;
    #1;
    chk("clr_state", state, 0);
    chk("clr_level", level, 0);
    chk("clr_playing", playing, 0);
    chk("clr_stb", move_stb, 0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    exp_q.push_back(160);
    go(4); serve = 1'b1;
    go(5); serve = 1'b0;
    go(31);
    chk("reserve_hold", state, 1);
    go(32);
    chk("reserve_play", state, 2);
    go(33); hit = 1'b1;
    go(34); hit = 1'b0;
    go(36);
    chk("post_clr_level", level, 0);

    go(200);
    chk("pending_strobes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
